csa_resolve: RTL and testbench

Sequential carry-propagate stage that consumes the redundant (sum, carry) vector pair produced by the carry-save module and resolves it into a single binary word. It sits after the carry-save tree in the multiplier datapath. It adds the two vectors CHUNK_WIDTH bits per cycle with a rippled chunk carry, which trades latency for a short critical path. Operands arrive on a valid/ready input handshake and the result leaves on a valid/ready output handshake.

---
 rtl/csa_resolve.sv | 130 +++++++++++++
 tb/tb_csa_resolve.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/csa_resolve.sv
// csa_resolve
// -----------------------------------------------------------------------------
// Sequential carry-propagate adder that resolves a carry-save (sum, carry)
// vector pair into one binary word. The add is done CHUNK_WIDTH bits per
// cycle, and the carry ripples from one chunk to the next across cycles. This
// keeps the critical path to one CHUNK_WIDTH-bit adder.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds its data and valid until
// that transfer. in_ready and out_valid are decoded from the FSM state only,
// so no input feeds an output combinationally.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operand pair present on sum_in/carry_in
//   in_ready   block is idle and can accept an operand pair
//   sum_in     carry-save sum vector
//   carry_in   carry-save carry vector (already aligned; bit 0 may be set)
//   out_valid  result/carry_out valid, held until out_ready
//   out_ready  downstream accepts the result
//   result     (sum_in + carry_in) mod 2^DATA_WIDTH
//   carry_out  bit DATA_WIDTH of the full sum (unsigned overflow)
//   fsm_state  current FSM state (0 idle, 1 add, 2 done) for observation
//
// DATA_WIDTH must be an integer multiple of CHUNK_WIDTH.
// -----------------------------------------------------------------------------
module csa_resolve #(
  parameter int DATA_WIDTH  = 64,
  parameter int CHUNK_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] sum_in,
  input  logic [DATA_WIDTH-1:0] carry_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry_out,
  output logic [1:0]            fsm_state
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  op_sum;
  logic [DATA_WIDTH-1:0]  op_carry;
  logic [IDX_W-1:0]       idx;
  logic                   chunk_carry;

  logic [CHUNK_WIDTH-1:0] chunk_a;
  logic [CHUNK_WIDTH-1:0] chunk_b;
  logic [CHUNK_WIDTH:0]   chunk_total;

  assign fsm_state = state;
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Select the operand chunk addressed by idx with an explicit mux rather
  // than a variable part-select, so the shifter stays a plain N-way mux.
  always_comb begin
    chunk_a = '0;
    chunk_b = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx == IDX_W'(i)) begin
        chunk_a = op_sum[i*CHUNK_WIDTH +: CHUNK_WIDTH];
        chunk_b = op_carry[i*CHUNK_WIDTH +: CHUNK_WIDTH];
      end
    end
    chunk_total = {1'b0, chunk_a} + {1'b0, chunk_b}
                + {{CHUNK_WIDTH{1'b0}}, chunk_carry};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      op_sum      <= '0;
      op_carry    <= '0;
      idx         <= '0;
      chunk_carry <= 1'b0;
      result      <= '0;
      carry_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_sum      <= sum_in;
            op_carry    <= carry_in;
            idx         <= '0;
            chunk_carry <= 1'b0;
            state       <= ADD;
          end
        end
        ADD: begin
          // Only the addressed chunk of result is written; the others keep
          // their old contents until their turn (hidden while out_valid=0).
          for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx == IDX_W'(i)) begin
              result[i*CHUNK_WIDTH +: CHUNK_WIDTH] <= chunk_total[CHUNK_WIDTH-1:0];
            end
          end
          chunk_carry <= chunk_total[CHUNK_WIDTH];
          if (idx == LAST_IDX) begin
            carry_out <= chunk_total[CHUNK_WIDTH];
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_resolve.sv
// tb_csa_resolve
// -----------------------------------------------------------------------------
// Bench for csa_resolve. Directed cases cover reset, latency, full ripple,
// backpressure, mid-operation reset and input isolation; a randomized phase
// with random out_ready follows. Expected results come from a plain 65-bit
// addition and are queued at each accept; a monitor pops and compares them at
// every output handshake.
// -----------------------------------------------------------------------------
module tb_csa_resolve;

  localparam int W  = 64;
  localparam int CW = 16;
  localparam int N  = W / CW;

  // clock / reset
  logic         clk       = 1'b0;
  logic         reset_n   = 1'b1;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum_in    = '0;
  logic [W-1:0] carry_in  = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         carry_out;
  logic [1:0]   fsm_state;

  always #5 clk = ~clk;

  csa_resolve #(.DATA_WIDTH(W), .CHUNK_WIDTH(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_in    (sum_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry_out (carry_out),
    .fsm_state (fsm_state)
  );

  // scoreboard state
  int           total = 0;
  int           bad   = 0;
  logic [W:0]   exp_q[$];
  bit           rand_bp = 1'b0;

  localparam logic [W-1:0] ALL1 = {W{1'b1}};

  function automatic logic [W:0] model(input logic [W-1:0] s, input logic [W-1:0] c);
    return {1'b0, s} + {1'b0, c};
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  // driver: present an operand pair, wait for in_ready, push expected on accept
  task automatic send(input logic [W-1:0] s, input logic [W-1:0] c, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    sum_in   = s;
    carry_in = c;
    while (!in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      timeout("accept_wait");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(model(s, c));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!out_valid) timeout("out_valid_wait");
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0 || out_valid) timeout("drain");
  endtask

  // monitor: compare at every output handshake, sampled on the falling edge
  initial begin
    logic [W:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && out_valid) begin
        check("in_ready_while_done", {{W{1'b0}}, in_ready}, '0);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got 0x%0h want none", {carry_out, result});
          end else begin
            e = exp_q.pop_front();
            check("result", {carry_out, result}, e);
          end
        end
      end
    end
  end

  // random backpressure
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int w;
    int lat;
    logic [W-1:0] s;
    logic [W-1:0] c;

    // reset state
    #2 reset_n = 1'b0;
    #1;
    check("reset_in_ready", {{W{1'b0}}, in_ready}, 1);
    check("reset_out_valid", {{W{1'b0}}, out_valid}, 0);
    check("reset_result", {carry_out, result}, '0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // basic add and latency
    out_ready = 1'b0;
    send(64'h5, 64'h3, w);
    wait_valid(lat);
    check("basic_latency", lat, N);
    drain();
    out_ready = 1'b0;

    // full ripple under backpressure
    send(ALL1, 64'h1, w);
    wait_valid(lat);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", {{W{1'b0}}, out_valid}, 1);
      check("bp_in_ready", {{W{1'b0}}, in_ready}, 0);
      check("bp_result_held", {carry_out, result}, {1'b1, {W{1'b0}}});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", {{W{1'b0}}, out_valid}, 0);
    check("bp_release_ready", {{W{1'b0}}, in_ready}, 1);

    // carry-save chain: A=7,B=5,C=3 -> sum 0x1, carry 0xE
    send(64'h1, 64'hE, w);
    drain();

    // input isolation: second pair waits for IDLE
    out_ready = 1'b1;
    send(64'h10, 64'h20, w);
    send(ALL1, ALL1, w);
    check("isolation_wait", w, N + 1);
    drain();

    // reset in the 2nd ADD cycle
    out_ready = 1'b0;
    send(64'h1234, 64'h0, w);
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("midreset_out_valid", {{W{1'b0}}, out_valid}, 0);
    check("midreset_result", {carry_out, result}, '0);
    check("midreset_in_ready", {{W{1'b0}}, in_ready}, 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    check("post_reset_in_ready", {{W{1'b0}}, in_ready}, 1);
    send(64'h1, 64'h1, w);
    drain();

    // randomized phase
    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: begin s = ALL1; c = {32'h0, $urandom()}; end
        1: begin s = {$urandom(), $urandom()}; c = ~s; end
        2: begin s = {$urandom(), $urandom()}; c = ALL1; end
        default: begin s = {$urandom(), $urandom()}; c = {$urandom(), $urandom()}; end
      endcase
      send(s, c, w);
    end
    rand_bp = 1'b0;
    @(posedge clk); #2;
    drain();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
